fb_word_packer: RTL and testbench
=================================

# fb_word_packer

Packs the 1-bit scaled pixel stream from the scaler into 16-bit Mac SE frame-buffer words and writes them to the frame-buffer RAM port. It sits directly downstream of the scaler and upstream of the frame-buffer RAM wrapper. The scaler has no backpressure, so this block absorbs RAM stalls in a small word FIFO.

## Interface

**Parameters**
- OUTPUT_WIDTH, 512: frame width in pixels; must be a multiple of 16.
- OUTPUT_HEIGHT, 342: frame height in lines.
- FIFO_DEPTH, 4: depth of the word FIFO; must be a power of two.
- INVERT, 1: when 1, the stored bit is ~scaled_mono_pixel. Scaler 1 = white; Mac SE 1 = black.

**Ports**
- clk, input, 1: single clock; every port is synchronous to it.
- reset, input, 1: asynchronous, active-high.
- scaled_write_enable, input, 1: pixel strobe from the scaler.
- scaled_mono_pixel, input, 1: pixel value.
- scaled_write_x, input, $clog2(OUTPUT_WIDTH): pixel column.
- scaled_write_y, input, $clog2(OUTPUT_HEIGHT): pixel row.
- frame_end, input, 1: one-cycle pulse; forces a flush of the partial word.
- mem_ready, input, 1: RAM accepts a write this cycle.
- mem_we, output, 1: write valid.
- mem_addr, output, 14: word address, y*(OUTPUT_WIDTH/16) + x[msb:4].
- mem_wdata, output, 16: pixel data; bit 15 = leftmost pixel (x[3:0]=0).
- mem_wmask, output, 16: per-bit write mask; 1 = bit valid.
- overflow, output, 1: sticky; set when a word is dropped because the FIFO was full.

## Operation

**Accumulator**
- State: acc_addr, acc_data, acc_mask.
- Reset value: acc_mask = 0.
- Bit index of an accepted pixel: b = 15 - x[3:0].

**Pixel acceptance**
- A pixel is accepted when scaled_write_enable = 1 and y < OUTPUT_HEIGHT.
- Pixels with y ≥ OUTPUT_HEIGHT are dropped silently, with no state change.

**Per-cycle rules** (evaluated in order, all at one clock edge)
1. **Address change.** Accepted pixel with word address ≠ acc_addr and acc_mask ≠ 0:
   - Push {acc_addr, acc_data, acc_mask} to the FIFO.
   - Reload the accumulator with the new pixel only.
2. **Merge.** Accepted pixel with the same address, or acc_mask = 0:
   - Set bit b of acc_data and acc_mask.
   - A repeated x overwrites the bit.
3. **Full word.** If the mask resulting from rule 1 or 2 equals 0xFFFF:
   - Push the completed word in the same edge.
   - Clear acc_mask.
   - If rule 1 also pushes in this edge, the full-word push is deferred one cycle.
4. **frame_end.** A pulse with acc_mask ≠ 0:
   - Flush the partial word.
   - If the same edge already pushes (rule 1 or 3), latch flush_pending and flush the next cycle.
   - frame_end with acc_mask = 0 and no pending flush has no effect.

**Push-queue semantics**
- At most one FIFO push per edge.
- A deferred push takes priority over a new push in the following cycle.
- Consecutive pushes can only arise from isolated pixels, so a single pending register suffices.

**FIFO and RAM handshake**
- FIFO is first-word-fall-through.
- mem_we = FIFO non-empty. mem_addr, mem_wdata and mem_wmask show the head entry.
- The head is popped when mem_we & mem_ready.
- A push into a full FIFO with no simultaneous pop drops the pushed word and sets overflow.
- A push and a pop in the same cycle on a full FIFO is legal: no drop.
- overflow clears only on reset.

## Timing

**Reset values**
- mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wmask = 0, overflow = 0.
- FIFO empty, accumulator empty, flush_pending = 0.

**Latency**
- 16th pixel of a word accepted at edge N → mem_we = 1 from edge N (visible the cycle after the strobe).
- Partial word flushed by an address change → mem_we one edge after the first pixel of the next word.
- Throughput: one pixel per cycle sustained; one word write per cycle when mem_ready = 1.

**Reset mid-operation**
- Discards the accumulator and FIFO contents; no partial write is emitted.
- mem_we drops asynchronously.

## Structure

- **Package mac_se_pkg**:
  - MAC_WIDTH = 512, MAC_HEIGHT = 342
  - WORDS_PER_LINE = 32, FB_ADDR_W = 14, FB_WORD_W = 16
  - fb_word_t struct {addr, data, mask}
- **Sub-module fb_word_fifo**: FWFT synchronous FIFO of fb_word_t.
  - Ports: push, pop, full, empty, din, dout.
  - Same clk and asynchronous reset.
- Estimated size: packer about 180 lines, FIFO about 70 lines.

## Test plan

1. **Full word.** Reset; hold mem_ready = 1; feed x = 0..15, y = 0, pixel = 1 (white).
   - Required: one write with addr 0, wdata 0x0000, wmask 0xFFFF, one cycle after the x = 15 strobe.
2. **Isolated pixels.** Feed x = 100 then x = 200, y = 150, pixel = 0.
   - First write: addr 150*32 + 6 = 4806, wdata 0x0800, wmask 0x0800, on the x = 200 edge.
   - Then frame_end → addr 4812, wdata 0x0080, wmask 0x0080.
3. **Out-of-range row.** Pixel at y = 342 with enable.
   - Required: no write; accumulator unchanged.
4. **Backpressure.** mem_ready = 0; produce 5 completed words (x = 0..79).
   - Required: 4 writes held; overflow = 1 after the 5th word.
   - Release mem_ready → words 0–3 written in order; overflow stays 1.
5. **Coincident frame_end.** frame_end in the same cycle as a pixel at a new word address.
   - Required: old word written, then the new pixel's partial word written one cycle later.
6. **Reset mid-operation.** Assert reset with 2 FIFO entries queued.
   - Required: mem_we = 0 immediately; no writes after release until new pixels arrive.

Source files
------------

// File: rtl/mac_se_pkg.sv
// Mac SE frame-buffer geometry and the word record carried from the packer to the RAM port.
package mac_se_pkg;

  localparam int MAC_WIDTH      = 512;
  localparam int MAC_HEIGHT     = 342;
  localparam int WORDS_PER_LINE = MAC_WIDTH / 16;
  localparam int FB_ADDR_W      = 14;
  localparam int FB_WORD_W      = 16;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_WORD_W-1:0] data;
    logic [FB_WORD_W-1:0] mask;
  } fb_word_t;

endpackage

// File: rtl/fb_word_fifo.sv
// First-word-fall-through FIFO of frame-buffer words; pushes into a full FIFO are ignored
// unless a pop frees the slot in the same cycle.
module fb_word_fifo
  import mac_se_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  fb_word_t din,
  output fb_word_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fb_word_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fb_word_packer.sv
// Packs the scaler's 1-bit pixel stream into masked 16-bit frame-buffer words and queues
// them for the frame-buffer RAM, absorbing RAM stalls in a small FIFO.
module fb_word_packer
  import mac_se_pkg::*;
#(
  parameter int OUTPUT_WIDTH  = MAC_WIDTH,
  parameter int OUTPUT_HEIGHT = MAC_HEIGHT,
  parameter int FIFO_DEPTH    = 4,
  parameter int INVERT        = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             scaled_write_enable,
  input  logic                             scaled_mono_pixel,
  input  logic [$clog2(OUTPUT_WIDTH)-1:0]  scaled_write_x,
  input  logic [$clog2(OUTPUT_HEIGHT)-1:0] scaled_write_y,
  input  logic                             frame_end,
  input  logic                             mem_ready,
  output logic                             mem_we,
  output logic [FB_ADDR_W-1:0]             mem_addr,
  output logic [FB_WORD_W-1:0]             mem_wdata,
  output logic [FB_WORD_W-1:0]             mem_wmask,
  output logic                             overflow
);

  localparam int XW  = $clog2(OUTPUT_WIDTH);
  localparam int WPL = OUTPUT_WIDTH / 16;

  fb_word_t             acc, acc_next;
  fb_word_t             pend_word, pend_next;
  logic                 pend_valid, pend_next_v;
  fb_word_t             cand [4];
  logic [3:0]           cand_v;
  fb_word_t             push_word, head;
  logic                 push, pop, full, empty;
  logic                 accept, pix_bit;
  logic [3:0]           bidx;
  logic [FB_ADDR_W-1:0] pix_addr;

  assign accept   = scaled_write_enable && (int'(scaled_write_y) < OUTPUT_HEIGHT);
  assign pix_bit  = (INVERT != 0) ? ~scaled_mono_pixel : scaled_mono_pixel;
  assign bidx     = ~scaled_write_x[3:0];
  assign pix_addr = FB_ADDR_W'(scaled_write_y) * FB_ADDR_W'(WPL)
                  + FB_ADDR_W'(scaled_write_x[XW-1:4]);

  // Candidates in emission order: deferred word, address-change word, full word, frame flush.
  // The first goes to the FIFO now, the second waits one cycle; a deferred frame flush
  // snapshots the post-edge accumulator, matching a flush performed on the next cycle.
  always_comb begin
    acc_next = acc;
    cand_v   = '0;
    for (int unsigned i = 0; i < 4; i++) cand[i] = '0;
    cand_v[0] = pend_valid;
    cand[0]   = pend_word;
    if (accept) begin
      if ((acc.mask != '0) && (pix_addr != acc.addr)) begin
        cand_v[1]     = 1'b1;
        cand[1]       = acc;
        acc_next.data = '0;
        acc_next.mask = '0;
      end
      acc_next.addr       = pix_addr;
      acc_next.data[bidx] = pix_bit;
      acc_next.mask[bidx] = 1'b1;
      if (&acc_next.mask) begin
        cand_v[2] = 1'b1;
        cand[2]   = acc_next;
        acc_next.data = '0;
        acc_next.mask = '0;
      end
    end
    if (frame_end && (acc.mask != '0) && (acc_next.mask != '0)) begin
      cand_v[3] = 1'b1;
      cand[3]   = acc_next;
      acc_next.data = '0;
      acc_next.mask = '0;
    end

    push        = 1'b0;
    push_word   = '0;
    pend_next_v = 1'b0;
    pend_next   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (cand_v[i]) begin
        if (!push) begin
          push      = 1'b1;
          push_word = cand[i];
        end else if (!pend_next_v) begin
          pend_next_v = 1'b1;
          pend_next   = cand[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      pend_word  <= '0;
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      acc        <= acc_next;
      pend_word  <= pend_next;
      pend_valid <= pend_next_v;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign pop = ~empty & mem_ready;

  fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign mem_we    = ~empty;
  assign mem_addr  = empty ? '0 : head.addr;
  assign mem_wdata = empty ? '0 : head.data;
  assign mem_wmask = empty ? '0 : head.mask;

endmodule

// File: tb/tb_fb_word_packer.sv
// Self-checking bench for fb_word_packer: directed scenarios plus a randomized stream
// compared against a word-level reference model.
module tb_fb_word_packer;

  typedef struct {
    logic [13:0] a;
    logic [15:0] d;
    logic [15:0] m;
    int          e;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scaled_write_enable = 1'b0;
  logic        scaled_mono_pixel = 1'b0;
  logic [8:0]  scaled_write_x = '0;
  logic [8:0]  scaled_write_y = '0;
  logic        frame_end = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_wmask;
  logic        overflow;

  int nchecks = 0;
  int npass   = 0;
  int edge_cnt = 0;
  wr_t obs[$];
  wr_t exp_q[$];

  // model state: one 16-pixel word, indexed by column within the word
  int   m_addr;
  logic m_val [16];
  logic m_bit [16];

  fb_word_packer #(
    .OUTPUT_WIDTH (512),
    .OUTPUT_HEIGHT(342),
    .FIFO_DEPTH   (4),
    .INVERT       (1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .scaled_write_enable(scaled_write_enable),
    .scaled_mono_pixel  (scaled_mono_pixel),
    .scaled_write_x     (scaled_write_x),
    .scaled_write_y     (scaled_write_y),
    .frame_end          (frame_end),
    .mem_ready          (mem_ready),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_wmask          (mem_wmask),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    wr_t w;
    if (!reset && mem_we && mem_ready) begin
      w.a = mem_addr; w.d = mem_wdata; w.m = mem_wmask; w.e = edge_cnt;
      obs.push_back(w);
    end
  end

  task automatic step(input logic we, input logic pix, input int x, input int y,
                      input logic fe, output int e);
    scaled_write_enable = we;
    scaled_mono_pixel   = pix;
    scaled_write_x      = 9'(x);
    scaled_write_y      = 9'(y);
    frame_end           = fe;
    e = edge_cnt + 1;
    @(posedge clk); #2;
    scaled_write_enable = 1'b0;
    frame_end           = 1'b0;
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) step(1'b0, 1'b0, 0, 0, 1'b0, e);
  endtask

  function automatic wr_t mk(input int a, input int d, input int m);
    wr_t w;
    w.a = 14'(a); w.d = 16'(d); w.m = 16'(m); w.e = 0;
    return w;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic m_any();
    for (int i = 0; i < 16; i++) if (m_val[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_all();
    for (int i = 0; i < 16; i++) if (!m_val[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_emit();
    int d = 0, m = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_val[i]) begin
        m += (1 << (15 - i));
        if (m_bit[i]) d += (1 << (15 - i));
      end
      m_val[i] = 1'b0;
      m_bit[i] = 1'b0;
    end
    exp_q.push_back(mk(m_addr, d, m));
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin m_val[i] = 1'b0; m_bit[i] = 1'b0; end
    m_addr = 0;
  endtask

  task automatic m_cycle(input logic we, input logic pix, input int x, input int y,
                         input logic fe);
    logic pre = m_any();
    int   a   = y * 32 + x / 16;
    if (we && y < 342) begin
      if (pre && a != m_addr) m_emit();
      m_addr = a;
      m_val[x % 16] = 1'b1;
      m_bit[x % 16] = ~pix;
      if (m_all()) m_emit();
    end
    if (fe && pre && m_any()) m_emit();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    nchecks++; if (mem_we !== 1'b0) $display("FAIL reset_we got=%b want=0", mem_we); else npass++;
    nchecks++; if (mem_addr !== 14'd0) $display("FAIL reset_addr got=%0d want=0", mem_addr); else npass++;
    nchecks++; if (mem_wdata !== 16'h0) $display("FAIL reset_wdata got=%h want=0000", mem_wdata); else npass++;
    nchecks++; if (mem_wmask !== 16'h0) $display("FAIL reset_wmask got=%h want=0000", mem_wmask); else npass++;
    nchecks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b want=0", overflow); else npass++;
    @(posedge clk); #2;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_full_word();
    int e;
    obs.delete();
    mem_ready = 1'b1;
    for (int x = 0; x < 16; x++) step(1'b1, 1'b1, x, 0, 1'b0, e);
    idle(3);
    nchecks++;
    if (obs.size() != 1) $display("FAIL full_word_count got=%0d want=1", obs.size());
    else if (obs[0].a !== 14'd0 || obs[0].d !== 16'h0000 || obs[0].m !== 16'hFFFF || obs[0].e != e)
      $display("FAIL full_word got=%0d/%h/%h@%0d want=0/0000/ffff@%0d", obs[0].a, obs[0].d, obs[0].m, obs[0].e, e);
    else npass++;
  endtask

  task automatic test_isolated();
    int e1, e2, e3;
    obs.delete();
    step(1'b1, 1'b0, 100, 150, 1'b0, e1);
    step(1'b1, 1'b0, 200, 150, 1'b0, e2);
    idle(2);
    step(1'b0, 1'b0, 0, 0, 1'b1, e3);
    idle(3);
    nchecks++;
    if (obs.size() != 2) $display("FAIL isolated_count got=%0d want=2", obs.size());
    else begin
      npass++;
      nchecks++;
      if (obs[0].a !== 14'd4806 || obs[0].d !== 16'h0800 || obs[0].m !== 16'h0800 || obs[0].e != e2)
        $display("FAIL isolated_first got=%0d/%h/%h@%0d want=4806/0800/0800@%0d", obs[0].a, obs[0].d, obs[0].m, obs[0].e, e2);
      else npass++;
      nchecks++;
      if (obs[1].a !== 14'd4812 || obs[1].d !== 16'h0080 || obs[1].m !== 16'h0080 || obs[1].e != e3)
        $display("FAIL isolated_flush got=%0d/%h/%h@%0d want=4812/0080/0080@%0d", obs[1].a, obs[1].d, obs[1].m, obs[1].e, e3);
      else npass++;
    end
  endtask

  task automatic test_out_of_range();
    int e;
    obs.delete();
    step(1'b1, 1'b0, 37, 10, 1'b0, e);
    step(1'b1, 1'b1, 200, 342, 1'b0, e);
    step(1'b1, 1'b0, 3, 511, 1'b0, e);
    idle(3);
    nchecks++;
    if (obs.size() != 0) $display("FAIL oor_no_write got=%0d want=0", obs.size()); else npass++;
    step(1'b0, 1'b0, 0, 0, 1'b1, e);
    idle(3);
    nchecks++;
    if (obs.size() != 1 || obs[0].a !== 14'd322 || obs[0].d !== 16'h0400 || obs[0].m !== 16'h0400)
      $display("FAIL oor_acc_kept got=%0d writes want=1 write 322/0400/0400", obs.size());
    else npass++;
  endtask

  task automatic test_coincident();
    int e;
    obs.delete();
    step(1'b1, 1'b0, 16, 2, 1'b0, e);
    step(1'b1, 1'b0, 48, 2, 1'b1, e);
    idle(4);
    nchecks++;
    if (obs.size() != 2) $display("FAIL coincident_count got=%0d want=2", obs.size());
    else begin
      npass++;
      nchecks++;
      if (obs[0].a !== 14'd65 || obs[0].m !== 16'h8000 || obs[0].e != e)
        $display("FAIL coincident_old got=%0d/%h@%0d want=65/8000@%0d", obs[0].a, obs[0].m, obs[0].e, e);
      else npass++;
      nchecks++;
      if (obs[1].a !== 14'd67 || obs[1].d !== 16'h8000 || obs[1].m !== 16'h8000 || obs[1].e != e + 1)
        $display("FAIL coincident_new got=%0d/%h/%h@%0d want=67/8000/8000@%0d", obs[1].a, obs[1].d, obs[1].m, obs[1].e, e + 1);
      else npass++;
    end
  endtask

  task automatic test_random();
    int   e, r, x, y, bad;
    logic we, pix, fe;
    obs.delete();
    exp_q.delete();
    m_clear();
    x = 0; y = 20;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      we = 1'b0; fe = 1'b0;
      pix = 1'($urandom_range(0, 1));
      if (r < 70) begin
        we = 1'b1;
        x = (x + 1) % 512;
        if (x == 0) y = (y + 1) % 342;
      end else if (r < 78) begin
        we = 1'b1;
        x = $urandom_range(0, 511);
        y = $urandom_range(0, 341);
      end else if (r < 82) begin
        we = 1'b1;
        y = $urandom_range(342, 511);
      end else if (r < 86) begin
        fe = 1'b1;
      end else if (r < 90) begin
        we = 1'b1; fe = 1'b1;
        x = $urandom_range(0, 511);
      end
      m_cycle(we, pix, x, y, fe);
      step(we, pix, x, y, fe, e);
      if (y >= 342) y = 20;
    end
    m_cycle(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1, e);
    idle(5);
    nchecks++;
    if (obs.size() != exp_q.size()) $display("FAIL random_count got=%0d want=%0d", obs.size(), exp_q.size());
    else begin
      npass++;
      bad = 0;
      for (int i = 0; i < obs.size(); i++) begin
        if (obs[i].a !== exp_q[i].a || obs[i].d !== exp_q[i].d || obs[i].m !== exp_q[i].m) begin
          if (bad < 5)
            $display("FAIL random_word[%0d] got=%0d/%h/%h want=%0d/%h/%h", i,
                     obs[i].a, obs[i].d, obs[i].m, exp_q[i].a, exp_q[i].d, exp_q[i].m);
          bad++;
        end
      end
      nchecks++;
      if (bad != 0) $display("FAIL random_words got=%0d bad want=0", bad); else npass++;
    end
  endtask

  task automatic test_backpressure();
    int   e;
    logic pix;
    obs.delete();
    exp_q.delete();
    m_clear();
    mem_ready = 1'b0;
    for (int x = 0; x < 80; x++) begin
      pix = 1'($urandom_range(0, 1));
      m_cycle(1'b1, pix, x, 1, 1'b0);
      step(1'b1, pix, x, 1, 1'b0, e);
    end
    idle(2);
    nchecks++;
    if (overflow !== 1'b1) $display("FAIL bp_overflow got=%b want=1", overflow); else npass++;
    nchecks++;
    if (mem_we !== 1'b1 || mem_addr !== 14'd32 || obs.size() != 0)
      $display("FAIL bp_held got=we%b/addr%0d/%0d writes want=we1/addr32/0 writes", mem_we, mem_addr, obs.size());
    else npass++;
    mem_ready = 1'b1;
    idle(8);
    nchecks++;
    if (obs.size() != 4) $display("FAIL bp_drain_count got=%0d want=4", obs.size());
    else begin
      npass++;
      for (int i = 0; i < 4; i++) begin
        nchecks++;
        if (obs[i].a !== exp_q[i].a || obs[i].d !== exp_q[i].d || obs[i].m !== 16'hFFFF || obs[i].e != obs[0].e + i)
          $display("FAIL bp_word[%0d] got=%0d/%h/%h want=%0d/%h/ffff", i, obs[i].a, obs[i].d, obs[i].m,
                   exp_q[i].a, exp_q[i].d);
        else npass++;
      end
    end
    nchecks++;
    if (overflow !== 1'b1) $display("FAIL bp_overflow_sticky got=%b want=1", overflow); else npass++;
  endtask

  task automatic test_reset_mid();
    int e;
    obs.delete();
    mem_ready = 1'b0;
    for (int x = 0; x < 32; x++) step(1'b1, 1'b1, x, 3, 1'b0, e);
    step(1'b1, 1'b1, 40, 3, 1'b0, e);
    nchecks++;
    if (mem_we !== 1'b1) $display("FAIL rm_queued got=%b want=1", mem_we); else npass++;
    reset = 1'b1;
    #1;
    nchecks++;
    if (mem_we !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rm_async got=we%b/ovf%b want=we0/ovf0", mem_we, overflow);
    else npass++;
    @(posedge clk); #2;
    reset = 1'b0;
    mem_ready = 1'b1;
    step(1'b0, 1'b0, 0, 0, 1'b1, e);
    idle(6);
    nchecks++;
    if (obs.size() != 0) $display("FAIL rm_no_write got=%0d want=0", obs.size()); else npass++;
    step(1'b1, 1'b0, 5, 0, 1'b0, e);
    step(1'b0, 1'b0, 0, 0, 1'b1, e);
    idle(3);
    nchecks++;
    if (obs.size() != 1 || obs[0].a !== 14'd0 || obs[0].d !== 16'h0400 || obs[0].m !== 16'h0400)
      $display("FAIL rm_resume got=%0d writes want=1 write 0/0400/0400", obs.size());
    else npass++;
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_full_word();
        test_isolated();
        test_out_of_range();
        test_coincident();
        test_random();
        test_backpressure();
        test_reset_mid();
      end
      begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
      end
    join_any
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
